uart_rx_baud_gen: RTL and testbench
===================================

# uart_rx_baud_gen

Parametrised receive-side timing generator for the UART RX path. After a start-bit detection pulse it produces an oversampled tick stream, one mid-bit sample strobe per frame bit with the current bit index, and start/stop validity checks. The frame length is configurable: data bits, optional parity, and 1 or 2 stop bits. It sits between the RX start-edge detector and the RX shift register, and supersedes the fixed single-rate `rxd_clk`.

## Interface
Parameters:
- `CLK_FREQUENCE`, default 50_000_000: system clock frequency in Hz.
- `BPS`, default 9600: baud rate.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥4.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8.
- `PARITY_EN`, default 0: 1 adds one parity bit slot to the frame.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `rx_start` in 1: one-cycle start-bit-detected pulse.
- `rx_done` in 1: abort/finish request from downstream.
- `rx_in` in 1: serial line, already synchronised upstream.
- `busy` out 1: high while a frame is being timed.
- `os_tick` out 1: one-cycle pulse per oversample period.
- `sample_clk` out 1: one-cycle mid-bit strobe.
- `bit_idx` out 4: frame bit index, valid with `sample_clk`. 0 = start bit.
- `frame_end` out 1: pulses with the last stop-bit strobe.
- `start_err` out 1: pulse, start bit read high at its mid-point.
- `frame_err` out 1: pulse, a stop bit read low.

## Operation
- Derived constants:
  - `DIV = CLK_FREQUENCE / (BPS*OVERSAMPLE)`, integer-truncated. `DIV < 2` is an elaboration error.
  - `FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS`, at most 12.
- Counters:
  - `div_cnt` counts 0..DIV-1 and wraps.
  - `os_cnt` counts 0..OVERSAMPLE-1 and advances on each wrap of `div_cnt`.
  - `bit_idx` advances on each wrap of `os_cnt`.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START when `rx_start`=1 and `rx_done`=0. On this transition all counters clear to 0.
  - START → DATA after strobe index 0, provided `rx_in`=0 at the strobe.
  - START → IDLE if `rx_in`=1 at the strobe. `start_err` pulses with that strobe and no further strobes follow.
  - DATA → PAR (PARITY_EN=1) or → STOP after the strobe at index DATA_BITS.
  - PAR → STOP after its strobe.
  - STOP → IDLE after the strobe at index FRAME_BITS-1. `frame_end` pulses with that strobe.
- `frame_err` pulses with any stop-bit strobe that samples `rx_in`=0. The frame still completes.
- `rx_done`=1 in any non-IDLE state → IDLE at the next edge. It has priority over a coincident strobe or transition, so no output pulse is produced in that cycle.
- `rx_start` while busy is ignored; the counters are not restarted.
- `rx_start` and `rx_done` both high in IDLE → remain in IDLE.
- `os_tick` and `sample_clk` are only asserted outside IDLE.
- All outputs are registered.

## Timing
- Reset (`rst_n`=0 at an edge): state = IDLE and all counters = 0. `busy`, `os_tick`, `sample_clk`, `frame_end`, `start_err` and `frame_err` are 0, and `bit_idx`=0. This applies mid-frame: outputs are 0 from the next cycle, with no partial pulses.
- Edge 0 is defined as the edge that samples `rx_start`=1 in IDLE.
  - `busy` is high from after edge 0.
  - `os_tick` is high for one cycle after edges k·DIV, k ≥ 1.
  - `sample_clk` is high after edge (b·OVERSAMPLE + OVERSAMPLE/2)·DIV for b = 0..FRAME_BITS-1, with `bit_idx`=b in the same cycle.
  - `rx_in` is sampled at the edge that raises `sample_clk`.
- `busy` falls one cycle after the final strobe, after a `start_err` strobe, or after the `rx_done` edge.
- A new `rx_start` is accepted in the first cycle with `busy`=0.
- Defaults give DIV=325, so the bit period is 5200 cycles and the start-bit strobe follows edge 2600.

## Test plan
- **Nominal 8N1 timing.** Defaults, `rx_start` pulse, `rx_in` = 0, then 0x55 LSB-first, then 1. Required: 10 strobes after edges 2600, 7800, …, 49400; `bit_idx` = 0..9; `frame_end` with the 10th strobe; `busy` low after edge 49401; no error pulses.
- **False start.** `rx_in`=1 at the start strobe. Required: `start_err` after edge 2600; exactly one `sample_clk`; `busy` = 0 after edge 2601.
- **Abort mid-frame.** `rx_done` pulse at edge 20000. Required: `busy`=0 after edge 20000; no further `os_tick` or `sample_clk`. A new `rx_start` at edge 20010 restarts the timing from 0.
- **Restart ignored.** `rx_start` repeated at edges 1000 and 30000 during a frame. Required: strobe times are identical to the nominal 8N1 case.
- **8E2 frame.** PARITY_EN=1, STOP_BITS=2, with `rx_in`=0 at the first stop bit. Required: 12 strobes, the last after edge 59800; one `frame_err`, with the `bit_idx`=10 strobe; `frame_end` with `bit_idx`=11.
- **Reset mid-frame.** `rst_n`=0 at edge 15000. Required: all outputs 0 after edge 15000 and idle thereafter until the next `rx_start`.

Source files
------------

// File: rtl/uart_rx_baud_gen.sv
// Receive-side UART timing generator: oversample ticks, mid-bit sample strobes with
// bit index, and start/stop validity pulses for a configurable frame format.
module uart_rx_baud_gen #(
    parameter int CLK_FREQUENCE = 50_000_000,
    parameter int BPS           = 9600,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_EN     = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_start,
    input  logic       rx_done,
    input  logic       rx_in,
    output logic       busy,
    output logic       os_tick,
    output logic       sample_clk,
    output logic [3:0] bit_idx,
    output logic       frame_end,
    output logic       start_err,
    output logic       frame_err
);

    localparam int DIV        = CLK_FREQUENCE / (BPS * OVERSAMPLE);
    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       IDX_DATA  = 4'(DATA_BITS);
    localparam logic [3:0]       IDX_FINAL = 4'(FRAME_BITS - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_baud_gen: CLK_FREQUENCE/(BPS*OVERSAMPLE) must be at least 2");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
        $error("uart_rx_baud_gen: OVERSAMPLE must be even and at least 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_data_chk
        $error("uart_rx_baud_gen: DATA_BITS must be 5..8");
    end
    if ((PARITY_EN < 0) || (PARITY_EN > 1)) begin : g_par_chk
        $error("uart_rx_baud_gen: PARITY_EN must be 0 or 1");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_stop_chk
        $error("uart_rx_baud_gen: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;

    logic       busy_q, busy_d;
    logic       os_tick_q, os_tick_d;
    logic       sample_clk_q, sample_clk_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic       frame_end_q, frame_end_d;
    logic       start_err_q, start_err_d;
    logic       frame_err_q, frame_err_d;

    logic div_wrap;
    logic os_wrap;
    logic strobe;
    logic start_ok;

    assign div_wrap = (div_cnt_q == DIV_LAST);
    assign os_wrap  = div_wrap && (os_cnt_q == OS_LAST);
    assign strobe   = div_wrap && (os_cnt_q == OS_MID);
    // busy_q lingers one cycle after a frame ends, so a start is only taken once it drops
    assign start_ok = (state_q == S_IDLE) && !busy_q && rx_start && !rx_done;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        os_cnt_d     = os_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        busy_d       = 1'b0;
        os_tick_d    = 1'b0;
        sample_clk_d = 1'b0;
        bit_idx_d    = 4'd0;
        frame_end_d  = 1'b0;
        start_err_d  = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == S_IDLE) begin
            if (start_ok) begin
                state_d   = S_START;
                div_cnt_d = '0;
                os_cnt_d  = '0;
                bit_cnt_d = '0;
                busy_d    = 1'b1;
            end
        end else if (rx_done) begin
            state_d = S_IDLE;
        end else begin
            busy_d    = 1'b1;
            div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
            if (div_wrap) begin
                os_tick_d = 1'b1;
                os_cnt_d  = os_wrap ? '0 : os_cnt_q + 1'b1;
            end
            if (os_wrap) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (strobe) begin
                sample_clk_d = 1'b1;
                bit_idx_d    = bit_cnt_q;
                case (state_q)
                    S_START: begin
                        if (rx_in) begin
                            start_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (bit_cnt_q == IDX_DATA) begin
                            state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
                        end
                    end
                    S_PAR: begin
                        state_d = S_STOP;
                    end
                    S_STOP: begin
                        frame_err_d = !rx_in;
                        if (bit_cnt_q == IDX_FINAL) begin
                            frame_end_d = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            busy_q       <= 1'b0;
            os_tick_q    <= 1'b0;
            sample_clk_q <= 1'b0;
            bit_idx_q    <= 4'd0;
            frame_end_q  <= 1'b0;
            start_err_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            busy_q       <= busy_d;
            os_tick_q    <= os_tick_d;
            sample_clk_q <= sample_clk_d;
            bit_idx_q    <= bit_idx_d;
            frame_end_q  <= frame_end_d;
            start_err_q  <= start_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign busy       = busy_q;
    assign os_tick    = os_tick_q;
    assign sample_clk = sample_clk_q;
    assign bit_idx    = bit_idx_q;
    assign frame_end  = frame_end_q;
    assign start_err  = start_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_baud_gen.sv
// Bench for uart_rx_baud_gen: an 8N1 instance (DIV=5, OS=16) and an 8E2 instance (DIV=3, OS=8)
// checked every cycle against an edge-count timing model of the frame.
module tb_uart_rx_baud_gen;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] st, dn, rxi;
    logic [1:0] busy_w, tick_w, sc_w, fe_w, serr_w, ferr_w;
    logic [3:0] bidx0, bidx1;

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    bit   rand_mode = 0;

    bit   m_on [2];
    int   m_t0 [2];
    int   m_fin [2];
    logic fbits [2][12];

    int   cnt_sc [2];
    int   cnt_fe [2];
    int   cnt_serr [2];
    int   cnt_ferr [2];

    always #5 clk = ~clk;

    uart_rx_baud_gen #(
        .CLK_FREQUENCE(768_000), .BPS(9600), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)
    ) u_dut0 (
        .clk(clk), .rst_n(rstn), .rx_start(st[0]), .rx_done(dn[0]), .rx_in(rxi[0]),
        .busy(busy_w[0]), .os_tick(tick_w[0]), .sample_clk(sc_w[0]), .bit_idx(bidx0),
        .frame_end(fe_w[0]), .start_err(serr_w[0]), .frame_err(ferr_w[0])
    );

    uart_rx_baud_gen #(
        .CLK_FREQUENCE(230_400), .BPS(9600), .OVERSAMPLE(8),
        .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rstn), .rx_start(st[1]), .rx_done(dn[1]), .rx_in(rxi[1]),
        .busy(busy_w[1]), .os_tick(tick_w[1]), .sample_clk(sc_w[1]), .bit_idx(bidx1),
        .frame_end(fe_w[1]), .start_err(serr_w[1]), .frame_err(ferr_w[1])
    );

    function automatic int cdiv(int d); return (d != 0) ? 3 : 5;   endfunction
    function automatic int cos(int d);  return (d != 0) ? 8 : 16;  endfunction
    function automatic int cfb(int d);  return (d != 0) ? 12 : 10; endfunction
    function automatic int csb(int d);  return (d != 0) ? 2 : 1;   endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Line content for one frame: start bit, LSB-first data, even parity (8E2 only), stop bits.
    task automatic set_frame(input int d, input logic sbit, input logic [7:0] data, input logic [1:0] stop_low);
        int idx;
        fbits[d][0] = sbit;
        for (int i = 0; i < 8; i++) fbits[d][1+i] = data[i];
        idx = 9;
        if (d != 0) begin
            fbits[d][9] = ^data;
            idx = 10;
        end
        for (int s = 0; s < csb(d); s++) fbits[d][idx+s] = !stop_low[s];
    endtask

    task automatic rand_frame(input int d);
        logic [7:0] data;
        logic [1:0] sl;
        data  = 8'($urandom);
        sl[0] = ($urandom_range(0, 3) == 0);
        sl[1] = ($urandom_range(0, 3) == 0);
        set_frame(d, ($urandom_range(0, 7) == 0), data, sl);
    endtask

    task automatic clear_cnt();
        for (int d = 0; d < 2; d++) begin
            cnt_sc[d] = 0; cnt_fe[d] = 0; cnt_serr[d] = 0; cnt_ferr[d] = 0;
        end
    endtask

    // One clock edge: drive the line for the coming edge, advance the model, check both DUTs.
    task automatic step();
        logic [1:0] e_busy, e_tick, e_sc, e_fe, e_serr, e_ferr;
        int         e_idx [2];
        int         e, m, b, n;
        for (int d = 0; d < 2; d++) begin
            rxi[d] = 1'b1;
            if (m_on[d]) begin
                b = (cyc + 1 - m_t0[d]) / (cos(d) * cdiv(d));
                if (b < cfb(d)) rxi[d] = fbits[d][b];
            end
        end
        @(posedge clk);
        cyc++;
        n = cyc;
        for (int d = 0; d < 2; d++) begin
            e_busy[d] = 0; e_tick[d] = 0; e_sc[d] = 0; e_fe[d] = 0;
            e_serr[d] = 0; e_ferr[d] = 0; e_idx[d] = 0;
            if (!rstn) begin
                m_on[d] = 0;
            end else if (!m_on[d]) begin
                if (st[d] && !dn[d]) begin
                    m_on[d] = 1; m_t0[d] = n; m_fin[d] = -1; e_busy[d] = 1;
                    if (rand_mode) rand_frame(d);
                end
            end else if (m_fin[d] >= 0 && n == m_fin[d] + 1) begin
                m_on[d] = 0;
            end else if (dn[d]) begin
                m_on[d] = 0;
            end else begin
                e = n - m_t0[d];
                e_busy[d] = 1;
                if (e % cdiv(d) == 0) begin
                    e_tick[d] = 1;
                    m = e / cdiv(d);
                    if (m % cos(d) == cos(d) / 2) begin
                        b = m / cos(d);
                        e_sc[d]  = 1;
                        e_idx[d] = b;
                        if (b == 0 && rxi[d]) begin
                            e_serr[d] = 1; m_fin[d] = n;
                        end
                        if (b >= cfb(d) - csb(d)) e_ferr[d] = !rxi[d];
                        if (b == cfb(d) - 1) begin
                            e_fe[d] = 1; m_fin[d] = n;
                        end
                    end
                end
            end
        end
        #1;
        chk("d0.busy", busy_w[0], e_busy[0]);   chk("d1.busy", busy_w[1], e_busy[1]);
        chk("d0.os_tick", tick_w[0], e_tick[0]); chk("d1.os_tick", tick_w[1], e_tick[1]);
        chk("d0.sample_clk", sc_w[0], e_sc[0]);  chk("d1.sample_clk", sc_w[1], e_sc[1]);
        chk("d0.bit_idx", bidx0, e_idx[0]);      chk("d1.bit_idx", bidx1, e_idx[1]);
        chk("d0.frame_end", fe_w[0], e_fe[0]);   chk("d1.frame_end", fe_w[1], e_fe[1]);
        chk("d0.start_err", serr_w[0], e_serr[0]); chk("d1.start_err", serr_w[1], e_serr[1]);
        chk("d0.frame_err", ferr_w[0], e_ferr[0]); chk("d1.frame_err", ferr_w[1], e_ferr[1]);
        for (int d = 0; d < 2; d++) begin
            cnt_sc[d]   += int'(sc_w[d]);
            cnt_fe[d]   += int'(fe_w[d]);
            cnt_serr[d] += int'(serr_w[d]);
            cnt_ferr[d] += int'(ferr_w[d]);
        end
        st   = 2'b00;
        dn   = 2'b00;
        rstn = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        rstn = 1'b0; st = 2'b00; dn = 2'b00; rxi = 2'b11;
        for (int d = 0; d < 2; d++) begin
            m_on[d] = 0; m_t0[d] = 0; m_fin[d] = -1;
        end
        set_frame(0, 1'b0, 8'h00, 2'b00);
        set_frame(1, 1'b0, 8'h00, 2'b00);

        repeat (3) begin rstn = 1'b0; step(); end

        // Nominal 8N1 with 0x55
        set_frame(0, 1'b0, 8'h55, 2'b00);
        clear_cnt(); st[0] = 1'b1; step(); run(820);
        chk("nom.strobes", cnt_sc[0], 10);
        chk("nom.frame_end", cnt_fe[0], 1);
        chk("nom.errors", cnt_serr[0] + cnt_ferr[0], 0);

        // False start
        set_frame(0, 1'b1, 8'($urandom), 2'b00);
        clear_cnt(); st[0] = 1'b1; step(); run(60);
        chk("fs.strobes", cnt_sc[0], 1);
        chk("fs.start_err", cnt_serr[0], 1);
        chk("fs.busy", busy_w[0], 0);

        // Abort at edge 250, restart at edge 260
        set_frame(0, 1'b0, 8'($urandom), 2'b00);
        clear_cnt(); st[0] = 1'b1; step(); run(249);
        dn[0] = 1'b1; step(); run(9);
        st[0] = 1'b1; step(); run(820);
        chk("abort.strobes", cnt_sc[0], 13);
        chk("abort.frame_end", cnt_fe[0], 1);

        // Restart pulses during a frame are ignored
        set_frame(0, 1'b0, 8'($urandom), 2'b00);
        clear_cnt(); st[0] = 1'b1; step(); run(99);
        st[0] = 1'b1; step(); run(399);
        st[0] = 1'b1; step(); run(330);
        chk("restart.strobes", cnt_sc[0], 10);

        // 8E2 with the first stop bit low
        set_frame(1, 1'b0, 8'($urandom), 2'b01);
        clear_cnt(); st[1] = 1'b1; step(); run(300);
        chk("8e2.strobes", cnt_sc[1], 12);
        chk("8e2.frame_err", cnt_ferr[1], 1);
        chk("8e2.frame_end", cnt_fe[1], 1);

        // Start and done together in idle
        st[0] = 1'b1; dn[0] = 1'b1; step();
        chk("stdone.busy", busy_w[0], 0);

        // Reset mid-frame on both instances
        set_frame(0, 1'b0, 8'($urandom), 2'b00);
        set_frame(1, 1'b0, 8'($urandom), 2'b00);
        st = 2'b11; step(); run(199);
        rstn = 1'b0; step(); run(50);
        clear_cnt(); st = 2'b11; step(); run(820);
        chk("rst.d0_frame_end", cnt_fe[0], 1);
        chk("rst.d1_frame_end", cnt_fe[1], 1);

        // rx_start held high: each frame starts in the first cycle busy is low
        set_frame(1, 1'b0, 8'hA3, 2'b00);
        clear_cnt();
        repeat (700) begin st[1] = 1'b1; step(); end
        run(300);
        chk("b2b.strobes", cnt_sc[1], 36);
        chk("b2b.frame_end", cnt_fe[1], 3);

        // Randomised traffic on both instances
        rand_mode = 1;
        repeat (8000) begin
            st[0] = ($urandom_range(0, 99) == 0);
            st[1] = ($urandom_range(0, 59) == 0);
            dn[0] = ($urandom_range(0, 2999) == 0);
            dn[1] = ($urandom_range(0, 1499) == 0);
            rstn  = ($urandom_range(0, 4999) != 0);
            step();
        end
        rand_mode = 0;
        run(900);
        chk("end.d0_busy", busy_w[0], 0);
        chk("end.d1_busy", busy_w[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
